// File: rtl/mfsr_pkg.sv
// Shared definitions for the maximal-length shift-register counter:
// width limits, next-state source encoding and the per-width tap table.
package mfsr_pkg;

    localparam int unsigned MIN_WIDTH = 3;
    localparam int unsigned MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        SRC_HOLD = 2'd0,
        SRC_STEP = 2'd1,
        SRC_LOAD = 2'd2,
        SRC_SEED = 2'd3
    } next_src_e;

    // Bit i set means state bit i feeds the XOR; the top bit is always a tap.
    function automatic logic [15:0] tap_mask(input int unsigned width);
        logic [15:0] mask;
        case (width)
            3:       mask = 16'h0006;
            4:       mask = 16'h000C;
            5:       mask = 16'h0014;
            6:       mask = 16'h0030;
            7:       mask = 16'h0060;
            8:       mask = 16'h00B8;
            9:       mask = 16'h0110;
            10:      mask = 16'h0240;
            11:      mask = 16'h0500;
            12:      mask = 16'h0829;
            13:      mask = 16'h100D;
            14:      mask = 16'h2015;
            15:      mask = 16'h6000;
            16:      mask = 16'hD008;
            default: mask = 16'h0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mfsr_step.sv
// Combinational single step of the Fibonacci shift register, forward or inverse.
module mfsr_step
    import mfsr_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  logic             reverse_i,
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] state_o
);

    localparam logic [15:0]      TAPS_FULL = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

    logic w_fwd_fb;
    logic w_inv_top;

    assign w_fwd_fb = ^(state_i & TAPS);

    // Previous low bits are the current high bits, so the lost top bit is
    // recovered by removing the lower taps' contribution from the feedback.
    assign w_inv_top = state_i[0] ^ (^(state_i[WIDTH-1:1] & TAPS[WIDTH-2:0]));

    // Select forward or inverse next value.
    always_comb begin
        state_o = state_i;
        if (reverse_i) begin
            state_o = {w_inv_top, state_i[WIDTH-1:1]};
        end else begin
            state_o = {state_i[WIDTH-2:0], w_fwd_fb};
        end
    end

endmodule

// File: rtl/mfsr_counter.sv
// Maximal-length shift-register counter with load, bidirectional stepping,
// optional auto-reload at a terminal state and registered terminal-count flag.
module mfsr_counter
    import mfsr_pkg::*;
#(
    parameter int unsigned      WIDTH  = 9,
    parameter bit               RELOAD = 1'b1,
    parameter logic [WIDTH-1:0] SEED   = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             reverse_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic [WIDTH-1:0] terminal_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             err_o
);

    generate
        if ((WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
            $error("mfsr_counter: WIDTH must be within 3..16");
        end
        if (SEED == {WIDTH{1'b0}}) begin : g_bad_seed
            $error("mfsr_counter: SEED must be non-zero");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_err;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_next;
    logic             w_load_zero;
    logic             w_at_term;
    logic             w_err_next;
    next_src_e        w_src;

    mfsr_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .reverse_i(reverse_i),
        .state_i  (r_count),
        .state_o  (w_step)
    );

    assign w_load_zero = (load_value_i == {WIDTH{1'b0}});
    assign w_at_term   = (r_count == terminal_i);

    // Choose where the next state comes from; a zero load value always
    // diverts to SEED so the all-zero lock-up state is unreachable.
    always_comb begin
        w_src = SRC_HOLD;
        if (load_i) begin
            w_src = w_load_zero ? SRC_SEED : SRC_LOAD;
        end else if (enable_i) begin
            if (RELOAD && w_at_term) begin
                w_src = w_load_zero ? SRC_SEED : SRC_LOAD;
            end else begin
                w_src = SRC_STEP;
            end
        end else begin
            w_src = SRC_HOLD;
        end
    end

    // Form the next state value and the error pulse.
    always_comb begin
        w_next = r_count;
        case (w_src)
            SRC_HOLD: w_next = r_count;
            SRC_STEP: w_next = w_step;
            SRC_LOAD: w_next = load_value_i;
            SRC_SEED: w_next = SEED;
            default:  w_next = SEED;
        endcase
        w_err_next = (w_src == SRC_SEED);
    end

    // State, terminal flag and error registers; tc tracks the value being loaded.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_count <= SEED;
            r_tc    <= (SEED == terminal_i);
            r_err   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_tc    <= (w_next == terminal_i);
            r_err   <= w_err_next;
        end
    end

    assign count_o = r_count;
    assign tc_o    = r_tc;
    assign err_o   = r_err;

endmodule
